// File: rtl/imem_responder_pkg.sv
// ---------------------------------------------------------------------------
// imem_responder_pkg
// Shared constants and state encoding for the instruction-memory responder.
//   IMEM_ADDR_WIDTH : default instruction address width (RAM depth = 2**width)
//   INSTR_WIDTH     : default instruction word width
//   imem_state_t    : host-controlled IDLE / LOAD / RUN state encoding
// ---------------------------------------------------------------------------
package imem_responder_pkg;

    localparam int IMEM_ADDR_WIDTH = 10;
    localparam int INSTR_WIDTH     = 64;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_LOAD = 2'd1,
        IMEM_RUN  = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// ---------------------------------------------------------------------------
// imem_ram
// Simple dual-port program RAM: one synchronous write port and one
// synchronous registered read port. The array has no reset so that it maps
// onto block RAM.
// Ports:
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_en   : read enable (read data register updates only when set)
//   i_rd_addr : read address
//   o_rd_data : registered read data, valid the cycle after i_rd_en
// ---------------------------------------------------------------------------
module imem_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
// Instruction-memory responder for the fetch-side frontend. The host loads
// the program through a write port while in LOAD, then starts RUN; in RUN
// every fetch request is accepted and answered exactly RD_LATENCY cycles
// later with an address-tagged response. softmc_end returns to IDLE.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   host_load_req            : IDLE -> LOAD (clears load_count and wr_err)
//   host_wr_en/addr/data     : program write port, honoured in LOAD only
//   host_start               : LOAD -> RUN
//   softmc_end               : RUN -> IDLE
//   req_valid, req_addr      : fetch request
//   req_ready                : high in RUN (depends on state only)
//   resp_valid/addr/data     : in-order tagged response
//   state_o                  : 0 IDLE, 1 LOAD, 2 RUN
//   load_count               : writes accepted in LOAD, saturating at depth
//   wr_err                   : sticky, a write was attempted outside LOAD
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int IMEM_ADDR_WIDTH = imem_responder_pkg::IMEM_ADDR_WIDTH,
    parameter int INSTR_WIDTH     = imem_responder_pkg::INSTR_WIDTH,
    parameter int RD_LATENCY      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       host_load_req,
    input  logic                       host_wr_en,
    input  logic [IMEM_ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [INSTR_WIDTH-1:0]     host_wr_data,
    input  logic                       host_start,
    input  logic                       softmc_end,
    input  logic                       req_valid,
    input  logic [IMEM_ADDR_WIDTH-1:0] req_addr,
    output logic                       req_ready,
    output logic                       resp_valid,
    output logic [IMEM_ADDR_WIDTH-1:0] resp_addr,
    output logic [INSTR_WIDTH-1:0]     resp_data,
    output logic [1:0]                 state_o,
    output logic [IMEM_ADDR_WIDTH:0]   load_count,
    output logic                       wr_err
);

    import imem_responder_pkg::*;

    localparam logic [IMEM_ADDR_WIDTH:0] LOAD_MAX = {1'b1, {IMEM_ADDR_WIDTH{1'b0}}};

    imem_state_t                r_state;
    imem_state_t                w_state_nxt;
    logic [IMEM_ADDR_WIDTH:0]   r_load_count;
    logic                       r_wr_err;
    logic                       w_enter_load;
    logic                       w_wr_ok;
    logic                       w_accept;
    logic [INSTR_WIDTH-1:0]     w_ram_q;
    logic [INSTR_WIDTH-1:0]     w_data_last;
    logic [RD_LATENCY-1:0]      r_vld;
    logic [IMEM_ADDR_WIDTH-1:0] r_addr [RD_LATENCY];

    assign w_enter_load = (r_state == IMEM_IDLE) && host_load_req;
    assign w_wr_ok      = (r_state == IMEM_LOAD) && host_wr_en;
    assign req_ready    = (r_state == IMEM_RUN);
    assign w_accept     = req_valid && req_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IMEM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: each host/fetch pulse only acts in its own source state,
    // so a simultaneous load request and start in IDLE lands in LOAD.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IMEM_IDLE: if (host_load_req) w_state_nxt = IMEM_LOAD;
            IMEM_LOAD: if (host_start)    w_state_nxt = IMEM_RUN;
            IMEM_RUN:  if (softmc_end)    w_state_nxt = IMEM_IDLE;
            default:                      w_state_nxt = IMEM_IDLE;
        endcase
    end

    // Load counter: cleared when a load session opens, saturates at depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_count <= '0;
        end else if (w_enter_load) begin
            r_load_count <= '0;
        end else if (w_wr_ok && (r_load_count != LOAD_MAX)) begin
            r_load_count <= r_load_count + 1'b1;
        end
    end

    // Sticky write-error flag. A stray write in the very cycle that opens a
    // load session still counts as an error, so setting beats clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else if (host_wr_en && (r_state != IMEM_LOAD)) begin
            r_wr_err <= 1'b1;
        end else if (w_enter_load) begin
            r_wr_err <= 1'b0;
        end
    end

    imem_ram #(
        .ADDR_WIDTH (IMEM_ADDR_WIDTH),
        .DATA_WIDTH (INSTR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (host_wr_addr),
        .i_wr_data (host_wr_data),
        .i_rd_en   (w_accept),
        .i_rd_addr (req_addr),
        .o_rd_data (w_ram_q)
    );

    // Valid/address tag pipeline. Stage 0 lines up with the RAM's registered
    // read; the state machine never touches it, so in-flight fetches drain
    // after leaving RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_addr[0] <= req_addr;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    // Data stages after the RAM read register, present only for latency > 1.
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign w_data_last = w_ram_q;
        end else begin : g_latn
            logic [INSTR_WIDTH-1:0] r_dpipe [RD_LATENCY-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        r_dpipe[i] <= '0;
                    end
                end else begin
                    r_dpipe[0] <= w_ram_q;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        r_dpipe[i] <= r_dpipe[i-1];
                    end
                end
            end

            assign w_data_last = r_dpipe[RD_LATENCY-2];
        end
    endgenerate

    // The RAM read register has no reset, so data is masked by the valid
    // bit to keep the output at zero until a real response arrives.
    assign resp_valid = r_vld[RD_LATENCY-1];
    assign resp_addr  = r_addr[RD_LATENCY-1];
    assign resp_data  = r_vld[RD_LATENCY-1] ? w_data_last : '0;
    assign state_o    = r_state;
    assign load_count = r_load_count;
    assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
// Self-checking bench: directed steps followed by random traffic, compared
// each cycle against a behavioural model (program array, state variable and
// a queue of expected responses with due cycles). A second, narrow instance
// exercises load-count saturation and ignored host pulses.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          host_load_req;
    logic          host_wr_en;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_start;
    logic          softmc_end;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          resp_valid;
    logic [AW-1:0] resp_addr;
    logic [DW-1:0] resp_data;
    logic [1:0]    state_o;
    logic [AW:0]   load_count;
    logic          wr_err;

    // Narrow instance signals
    logic          s_load_req;
    logic          s_wr_en;
    logic [1:0]    s_wr_addr;
    logic [DW-1:0] s_wr_data;
    logic          s_start;
    logic          s_end;
    logic          s_req_valid;
    logic [1:0]    s_req_addr;
    logic          s_req_ready;
    logic          s_resp_valid;
    logic [1:0]    s_resp_addr;
    logic [DW-1:0] s_resp_data;
    logic [1:0]    s_state;
    logic [2:0]    s_load_count;
    logic          s_wr_err;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            known;
    } exp_t;

    exp_t          expQ[$];
    logic [DW-1:0] mMem   [DEPTH];
    bit            mKnown [DEPTH];
    int            mState = 0;
    int            mCount = 0;
    bit            mErr   = 1'b0;
    int            edgeN  = 0;

    imem_responder #(
        .IMEM_ADDR_WIDTH (AW),
        .INSTR_WIDTH     (DW),
        .RD_LATENCY      (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_load_req (host_load_req),
        .host_wr_en    (host_wr_en),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .host_start    (host_start),
        .softmc_end    (softmc_end),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_addr     (resp_addr),
        .resp_data     (resp_data),
        .state_o       (state_o),
        .load_count    (load_count),
        .wr_err        (wr_err)
    );

    imem_responder #(
        .IMEM_ADDR_WIDTH (2),
        .INSTR_WIDTH     (DW),
        .RD_LATENCY      (LAT)
    ) dutSmall (
        .clk           (clk),
        .rst           (rst),
        .host_load_req (s_load_req),
        .host_wr_en    (s_wr_en),
        .host_wr_addr  (s_wr_addr),
        .host_wr_data  (s_wr_data),
        .host_start    (s_start),
        .softmc_end    (s_end),
        .req_valid     (s_req_valid),
        .req_addr      (s_req_addr),
        .req_ready     (s_req_ready),
        .resp_valid    (s_resp_valid),
        .resp_addr     (s_resp_addr),
        .resp_data     (s_resp_data),
        .state_o       (s_state),
        .load_count    (s_load_count),
        .wr_err        (s_wr_err)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs, advances the model across the clock edge,
    // then compares every observable output 1 time unit after the edge.
    task automatic applyStimulus(input bit lreq, input bit wen, input logic [AW-1:0] waddr,
                                 input logic [DW-1:0] wdata, input bit start, input bit endp,
                                 input bit rv, input logic [AW-1:0] raddr);
        int oldState;
        host_load_req = lreq;
        host_wr_en    = wen;
        host_wr_addr  = waddr;
        host_wr_data  = wdata;
        host_start    = start;
        softmc_end    = endp;
        req_valid     = rv;
        req_addr      = raddr;
        @(posedge clk);
        edgeN++;
        if (rst) begin
            mState = 0;
            mCount = 0;
            mErr   = 1'b0;
            expQ.delete();
        end else begin
            oldState = mState;
            if (rv && oldState == 2) begin
                expQ.push_back('{edgeN + LAT - 1, raddr, mMem[raddr], mKnown[raddr]});
            end
            if (wen && oldState == 1) begin
                mMem[waddr]   = wdata;
                mKnown[waddr] = 1'b1;
                if (mCount < DEPTH) mCount++;
            end
            if (oldState == 0 && lreq) begin
                mState = 1;
                mCount = 0;
                mErr   = 1'b0;
            end else if (oldState == 1 && start) begin
                mState = 2;
            end else if (oldState == 2 && endp) begin
                mState = 0;
            end
            if (wen && oldState != 1) mErr = 1'b1;
        end
        #1;
        host_load_req = 1'b0;
        host_wr_en    = 1'b0;
        host_start    = 1'b0;
        softmc_end    = 1'b0;
        req_valid     = 1'b0;
        checkOutput("state", DW'(state_o), DW'(mState));
        checkOutput("req_ready", DW'(req_ready), DW'(mState == 2));
        checkOutput("load_count", DW'(load_count), DW'(mCount));
        checkOutput("wr_err", DW'(wr_err), DW'(mErr));
        if (expQ.size() > 0 && expQ[0].due == edgeN) begin
            checkOutput("resp_valid", DW'(resp_valid), 64'd1);
            checkOutput("resp_addr", DW'(resp_addr), DW'(expQ[0].addr));
            if (expQ[0].known) checkOutput("resp_data", resp_data, expQ[0].data);
            void'(expQ.pop_front());
        end else begin
            checkOutput("resp_idle", DW'(resp_valid), 64'd0);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, '0, '0, 0, 0, 0, '0);
    endtask

    // One clock of the narrow instance, all its pulses dropped afterwards.
    task automatic smallCycle();
        @(posedge clk);
        #1;
        s_load_req = 1'b0;
        s_wr_en    = 1'b0;
        s_start    = 1'b0;
        s_end      = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        host_load_req = 1'b0;
        host_wr_en    = 1'b0;
        host_wr_addr  = '0;
        host_wr_data  = '0;
        host_start    = 1'b0;
        softmc_end    = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        s_load_req    = 1'b0;
        s_wr_en       = 1'b0;
        s_wr_addr     = '0;
        s_wr_data     = '0;
        s_start       = 1'b0;
        s_end         = 1'b0;
        s_req_valid   = 1'b0;
        s_req_addr    = '0;
        for (int i = 0; i < DEPTH; i++) mKnown[i] = 1'b0;

        // Reset values
        #2;
        checkOutput("rst_state", DW'(state_o), 64'd0);
        checkOutput("rst_req_ready", DW'(req_ready), 64'd0);
        checkOutput("rst_resp_valid", DW'(resp_valid), 64'd0);
        checkOutput("rst_resp_addr", DW'(resp_addr), 64'd0);
        checkOutput("rst_resp_data", resp_data, 64'd0);
        checkOutput("rst_load_count", DW'(load_count), 64'd0);
        checkOutput("rst_wr_err", DW'(wr_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load addr 0..3 with 0x11..0x44, start, fetch addr 2
        $display("[TB] load and single fetch");
        applyStimulus(1, 0, '0, '0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, AW'(i), DW'((i + 1) * 'h11), 0, 0, 0, '0);
        end
        checkOutput("load_count_4", DW'(load_count), 64'd4);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, '0);
        applyStimulus(0, 0, '0, '0, 0, 0, 1, AW'(2));
        checkOutput("latency_not_early", DW'(resp_valid), 64'd0);
        idleCycle();
        checkOutput("fetch2_data", resp_data, 64'h33);
        idleCycle();

        // Back-to-back fetches
        $display("[TB] back-to-back fetch");
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, '0, 0, 0, 1, AW'(i));
        for (int i = 0; i < LAT; i++) idleCycle();

        // Gating: write in RUN, then fetch 0 must still see 0x11
        $display("[TB] gating");
        applyStimulus(0, 1, AW'(0), 64'hFF, 0, 0, 0, '0);
        checkOutput("wr_err_run", DW'(wr_err), 64'd1);
        applyStimulus(0, 0, '0, '0, 0, 0, 1, AW'(0));
        idleCycle();
        checkOutput("ram_unchanged", resp_data, 64'h11);
        applyStimulus(0, 0, '0, '0, 0, 1, 0, '0);
        applyStimulus(0, 0, '0, '0, 0, 0, 1, AW'(1));
        for (int i = 0; i < LAT; i++) applyStimulus(0, 0, '0, '0, 0, 0, 1, AW'(2));
        applyStimulus(1, 0, '0, '0, 1, 0, 1, AW'(1));
        checkOutput("load_over_start", DW'(state_o), 64'd1);
        for (int i = 0; i < LAT + 1; i++) applyStimulus(0, 0, '0, '0, 0, 0, 1, AW'(3));
        applyStimulus(0, 0, '0, '0, 1, 0, 0, '0);

        // softmc_end together with a request
        $display("[TB] softmc_end overlap");
        applyStimulus(0, 0, '0, '0, 0, 1, 1, AW'(1));
        checkOutput("end_to_idle", DW'(state_o), 64'd0);
        idleCycle();
        checkOutput("drain_valid", DW'(resp_valid), 64'd1);
        checkOutput("drain_data", resp_data, 64'h22);
        idleCycle();

        // Reset with a request in flight
        $display("[TB] reset mid-flight");
        applyStimulus(1, 0, '0, '0, 0, 0, 0, '0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, '0);
        applyStimulus(0, 0, '0, '0, 0, 0, 1, AW'(3));
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", DW'(resp_valid), 64'd0);
        checkOutput("midrst_state", DW'(state_o), 64'd0);
        idleCycle();
        rst = 1'b0;
        idleCycle();
        applyStimulus(1, 0, '0, '0, 0, 0, 0, '0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0, '0);
        applyStimulus(0, 0, '0, '0, 0, 0, 1, AW'(3));
        idleCycle();
        checkOutput("ram_retained", resp_data, 64'h44);
        applyStimulus(0, 0, '0, '0, 0, 1, 0, '0);
        idleCycle();

        // Random traffic against the model
        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            bit            lreq;
            bit            wen;
            bit            start;
            bit            endp;
            bit            rv;
            logic [AW-1:0] waddr;
            logic [AW-1:0] raddr;
            logic [DW-1:0] wdata;
            lreq  = ($urandom_range(0, 9) == 0);
            wen   = (mState == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            start = (mState == 1) ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 59) == 0);
            endp  = (mState == 2) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 59) == 0);
            rv    = ($urandom_range(0, 3) != 0);
            waddr = AW'($urandom_range(0, 31));
            raddr = AW'($urandom_range(0, 47));
            wdata = {$urandom, $urandom};
            applyStimulus(lreq, wen, waddr, wdata, start, endp, rv, raddr);
        end
        for (int i = 0; i < LAT; i++) idleCycle();
        checkOutput("queue_drained", DW'(expQ.size()), 64'd0);

        // Narrow instance: saturation and ignored start in IDLE
        $display("[TB] saturation");
        s_load_req = 1'b1;
        smallCycle();
        checkOutput("sat_state_load", DW'(s_state), 64'd1);
        for (int i = 0; i < 5; i++) begin
            s_wr_en   = 1'b1;
            s_wr_addr = 2'(i);
            s_wr_data = DW'(i + 1);
            smallCycle();
        end
        checkOutput("sat_count", DW'(s_load_count), 64'd4);
        checkOutput("sat_wr_err", DW'(s_wr_err), 64'd0);
        s_start = 1'b1;
        smallCycle();
        checkOutput("sat_state_run", DW'(s_state), 64'd2);
        s_end = 1'b1;
        smallCycle();
        checkOutput("sat_state_idle", DW'(s_state), 64'd0);
        s_start = 1'b1;
        smallCycle();
        checkOutput("start_in_idle", DW'(s_state), 64'd0);
        checkOutput("start_in_idle_ready", DW'(s_req_ready), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
